// File: rtl/gain_ctrl_pkg.sv
// Shared types and constants for the gain path: pot writer FSM states, request record, safe defaults.
package gain_ctrl_pkg;

    localparam int          POT_FRAME_W    = 16;
    localparam logic [7:0]  POT_CMD_WRITE  = 8'h11;
    localparam logic [7:0]  PGA_UNITY_CODE = 8'h80;
    localparam logic        HGA_SAFE       = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_SETTLE
    } pot_wr_state_t;

    typedef struct packed {
        logic       hga;
        logic [7:0] code;
    } pot_req_t;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK phase divider: tick marks the last cycle of each CLK_DIV-long SCLK phase.
// Latency: first tick CLK_DIV-1 cycles after en_i rises; combinational tick output.
// Backpressure: none; counter holds at zero while en_i is low.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick_o = en_i && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pga_pot_writer.sv
// Pot writer: serialises {POT_CMD, code} over mode-0 SPI, then applies HGA and waits for analog settle.
// Latency: busy for 34*CLK_DIV+SETTLE_CYCLES cycles from the cycle after update_i; done_o one cycle later.
// Backpressure: none; update_i while busy overwrites a one-deep pending slot. POT_WRITE_DEDUP_EN skips repeats.
module pga_pot_writer
    import gain_ctrl_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SETTLE_CYCLES = 16,
    parameter logic [7:0] POT_CMD       = POT_CMD_WRITE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] pga_code_i,
    input  logic       hga_active_i,
    input  logic       update_i,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    output logic       hga_en_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    pot_wr_state_t          state, state_nxt;
    logic [3:0]             bit_cnt, bit_nxt;
    logic                   phase_hi, hi_nxt;
    pot_req_t               act_req, act_nxt;
    pot_req_t               pend_req, in_req, start_src;
    logic                   pend_vld;
    logic                   start_req, start_dup, start_frame;
    logic                   done_nxt;
    logic                   div_en, div_tick;
    logic                   settle_last;
    logic [SW-1:0]          settle_cnt;
    logic [POT_FRAME_W-1:0] frame_nxt;

    assign in_req.hga  = hga_active_i;
    assign in_req.code = pga_code_i;

    // A fresh strobe always beats whatever is parked in the pending slot.
    assign start_src = update_i ? in_req : pend_req;
    assign start_req = update_i || pend_vld;

`ifdef POT_WRITE_DEDUP_EN
    pot_req_t last_req;
    logic     last_vld;

    assign start_dup = last_vld && (start_src == last_req);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_vld <= 1'b0;
            last_req <= '{hga: HGA_SAFE, code: PGA_UNITY_CODE};
        end else if (state == ST_SETTLE && settle_last) begin
            last_vld <= 1'b1;
            last_req <= act_req;
        end
    end
`else
    assign start_dup = 1'b0;
`endif

    assign start_frame = (state == ST_IDLE) && start_req && !start_dup;
    // Back-to-back frames keep busy high through the done cycle.
    assign busy_o      = (state != ST_IDLE) || (start_frame && (pend_vld || done_o));
    assign div_en      = (state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD);
    assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (div_en),
        .tick_o (div_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd15;
            phase_hi <= 1'b0;
            act_req  <= '{hga: HGA_SAFE, code: PGA_UNITY_CODE};
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            phase_hi <= hi_nxt;
            act_req  <= act_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        hi_nxt    = phase_hi;
        act_nxt   = act_req;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_frame) begin
                    state_nxt = ST_CS_SETUP;
                    act_nxt   = start_src;
                    bit_nxt   = 4'd15;
                    hi_nxt    = 1'b0;
                end else if (start_req && start_dup) begin
                    done_nxt  = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                if (div_tick) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_tick) begin
                    hi_nxt = !phase_hi;
                    if (phase_hi) begin
                        bit_nxt = bit_cnt - 4'd1;
                        if (bit_cnt == 4'd0) state_nxt = ST_CS_HOLD;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (div_tick) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign frame_nxt = {POT_CMD, act_nxt.code};

    // Pin outputs are registered from the next-state view so they never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spi_cs_n_o <= 1'b1;
            spi_sclk_o <= 1'b0;
            spi_mosi_o <= 1'b0;
            hga_en_o   <= HGA_SAFE;
            done_o     <= 1'b0;
            pend_vld   <= 1'b0;
            pend_req   <= '{hga: HGA_SAFE, code: PGA_UNITY_CODE};
            settle_cnt <= '0;
        end else begin
            spi_cs_n_o <= !((state_nxt == ST_CS_SETUP) || (state_nxt == ST_SHIFT) ||
                            (state_nxt == ST_CS_HOLD));
            spi_sclk_o <= (state_nxt == ST_SHIFT) && hi_nxt;
            if ((state_nxt == ST_CS_SETUP) || (state_nxt == ST_SHIFT)) begin
                spi_mosi_o <= frame_nxt[bit_nxt];
            end else if (state_nxt != ST_CS_HOLD) begin
                spi_mosi_o <= 1'b0;
            end
            if (state == ST_CS_HOLD && state_nxt == ST_SETTLE) begin
                hga_en_o <= act_req.hga;
            end
            done_o     <= done_nxt;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
            if (state == ST_IDLE) begin
                pend_vld <= 1'b0;
            end else if (update_i) begin
                pend_vld <= 1'b1;
                pend_req <= in_req;
            end
        end
    end

endmodule

// File: doc/pga_pot_writer.md
# pga_pot_writer

Sequential back end of the gain path: takes a PGA wiper code and HGA enable, serializes the code to the digital potentiometer over a write-only SPI link (mode 0, 16-bit frame), and applies the HGA bypass switch. The HGA switch is updated only when the new pot value latches, so both gain stages change together. Sits between the gain controller/LUT output and the analog front-end pins. Accepts a new request while busy through a one-deep, most-recent-wins pending slot.

## Interface
- CLK_DIV, 4: SCLK half-period in clk_i cycles; minimum 1.
- SETTLE_CYCLES, 16: analog settle wait after CS release; minimum 1.
- POT_CMD, 8'h11: command byte sent ahead of the data byte (write wiper 0).
- clk_i  in  1  system clock; one clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pga_code_i  in  8  requested wiper code.
- hga_active_i  in  1  requested HGA state (1 = HGA in path).
- update_i  in  1  single-cycle request strobe; samples pga_code_i/hga_active_i.
- spi_sclk_o  out  1  SPI clock, idles low.
- spi_mosi_o  out  1  SPI data, MSB first.
- spi_cs_n_o  out  1  chip select, active low.
- hga_en_o  out  1  HGA switch drive.
- busy_o  out  1  frame or settle in progress.
- done_o  out  1  one-cycle pulse: request applied and settled.

## Operation
- Reset values: spi_cs_n_o=1, spi_sclk_o=0, spi_mosi_o=0, hga_en_o=0 (bypass, safe), busy_o=0, done_o=0; pending slot empty; state IDLE.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> SETTLE -> IDLE.
- IDLE: update_i latches {hga, code} into the active register and moves to CS_SETUP next cycle.
- CS_SETUP: cs_n low, sclk low, mosi = frame bit 15, for CLK_DIV cycles.
- SHIFT: frame = {POT_CMD, code}, 16 bits MSB first. Each bit holds sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi changes only at the start of the low phase. The bit counter (4 bits) wraps after bit 0.
- CS_HOLD: sclk low, cs_n low, for CLK_DIV cycles.
- SETTLE: cs_n high and hga_en_o <= latched hga, both in the first SETTLE cycle. Lasts SETTLE_CYCLES cycles.
- Completion: done_o pulses in the cycle after SETTLE ends.
  - If a request is pending, or update_i is asserted in that cycle, the next frame starts: busy_o stays high and cs_n falls in the following cycle.
  - When both are present, update_i wins over pending.
- update_i while busy: overwrites the pending slot; it is never dropped mid-frame and the frame in flight is unaffected.
- Input values are sampled only on the update_i cycle; changes at other times are ignored.
- Divider counter width: $clog2(CLK_DIV+1); settle counter width: $clog2(SETTLE_CYCLES+1).

## Timing
- busy_o rises the cycle after update_i.
- busy duration: 34*CLK_DIV + SETTLE_CYCLES cycles.
- done_o follows at +1 from the end of the busy window. Example: CLK_DIV=2, SETTLE=4 → busy cycles 1..72, done_o at cycle 73.
- hga_en_o changes exactly in the cycle cs_n rises, never mid-frame.
- rst_i mid-frame: next cycle forces cs_n high, sclk low, hga_en_o 0, and clears the pending slot; no done_o pulse.

## Configuration
- POT_WRITE_DEDUP_EN defined:
  - The block keeps the last applied {hga, code}, valid after the first completed write.
  - An update_i in IDLE that matches it generates no SPI frame; done_o pulses the next cycle and busy_o stays low.
  - A matching pending request is handled the same way at frame end.
- POT_WRITE_DEDUP_EN undefined: every request produces a full frame and settle.

## Structure
- Shared package gain_ctrl_pkg holds:
  - pot_wr_state_t enum.
  - POT_FRAME_W = 16.
  - POT_CMD_WRITE = 8'h11, the default for POT_CMD.
  - Safe defaults PGA_UNITY_CODE = 8'h80 and HGA_SAFE = 1'b0.
- One sub-module: spi_sclk_div. It generates the phase-tick enables (low/high phase boundaries) from CLK_DIV, and counts only while enabled by the FSM.

## Test plan
- Reset, then update_i with code=8'hA5, hga=1 (CLK_DIV=2, SETTLE=4):
  - MOSI over 16 rising SCLK edges reads 16'h11A5.
  - cs_n is low over cycles 1..68.
  - hga_en_o goes 0→1 at cycle 69.
  - done_o pulses at cycle 73.
- update_i for 8'h80 during a frame, then again for 8'hDC before it ends:
  - Only 8'hDC is sent in the second frame.
  - busy_o stays high with no gap.
  - Two done_o pulses in total.
- update_i in the done_o cycle while pending holds 8'h4F: the update_i value is sent and the pending value is discarded.
- rst_i asserted at the 5th SCLK rise:
  - Next cycle, cs_n=1 and hga_en_o=0.
  - No done_o pulse.
  - A subsequent request runs a clean full frame.
- With POT_WRITE_DEDUP_EN, repeat of 8'hA5/hga=1:
  - No cs_n activity.
  - done_o the next cycle.
  - Changing only hga triggers a full frame.
- CLK_DIV=1: each SCLK phase lasts 1 cycle and the frame is exactly 34+SETTLE busy cycles.
